// File: rtl/imm_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Package   : imm_pkg                                                        |
// | Purpose   : Immediate format codes and per-format instruction field        |
// |             positions, shared by the immediate extender and imm_encoder.   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package imm_pkg;

  // Immediate format selector (2-bit, fully decoded)
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Field positions, in full 32-bit instruction bit numbers
  localparam int unsigned I_HI     = 31;  // imm[11:0]
  localparam int unsigned I_LO     = 20;

  localparam int unsigned S_UP_HI  = 31;  // imm[11:5]
  localparam int unsigned S_UP_LO  = 25;
  localparam int unsigned S_DN_HI  = 11;  // imm[4:0]
  localparam int unsigned S_DN_LO  = 7;

  localparam int unsigned B_SIGN   = 31;  // imm[12]
  localparam int unsigned B_UP_HI  = 30;  // imm[10:5]
  localparam int unsigned B_UP_LO  = 25;
  localparam int unsigned B_DN_HI  = 11;  // imm[4:1]
  localparam int unsigned B_DN_LO  = 8;
  localparam int unsigned B_B11    = 7;   // imm[11]

  localparam int unsigned J_SIGN   = 31;  // imm[20]
  localparam int unsigned J_DN_HI  = 30;  // imm[10:1]
  localparam int unsigned J_DN_LO  = 21;
  localparam int unsigned J_B11    = 20;  // imm[11]
  localparam int unsigned J_UP_HI  = 19;  // imm[19:12]
  localparam int unsigned J_UP_LO  = 12;

  // Sign-bit index of each format's immediate (range check boundary)
  localparam int unsigned I_SB = 11;
  localparam int unsigned B_SB = 12;
  localparam int unsigned J_SB = 20;

  // Packed result of one encode: instr[31:7] plus its two status flags
  typedef struct packed {
    logic [24:0] instr;
    logic        err;
    logic        misalign;
  } imm_res_t;

  // True when v[31:sb] are all copies of v[sb], i.e. v fits in sb+1 signed bits
  function automatic logic imm_fits(input logic [31:0] v, input int unsigned sb);
    logic [31:0] t;
    t = $signed(v) >>> sb;
    return (t == '0) || (t == '1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_pack.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module    : imm_pack                                                       |
// | Purpose   : Combinational packer: places a signed immediate into           |
// |             instr[31:7] for format I/S/B/J, keeping non-immediate bits     |
// |             from the base word, and flags range / alignment errors.        |
// | Ports     : i_immsrc  format select                                        |
// |             i_imm     32-bit signed immediate (byte offset for B/J)        |
// |             i_base    instr[31:7] template                                 |
// |             o_res     packed instr[31:7], err, misalign                    |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module imm_pack
  import imm_pkg::*;
(
  input  logic [1:0]  i_immsrc,
  input  logic [31:0] i_imm,
  input  logic [24:0] i_base,
  output imm_res_t    o_res
);

  logic [31:0] w_ins;
  logic        w_err;
  logic        w_mis;

  always_comb begin
    // Work on a full 32-bit word so field positions read as instruction bits
    w_ins = {i_base, 7'b0};
    w_err = 1'b0;
    w_mis = 1'b0;
    case (i_immsrc)
      IMM_I: begin
        w_ins[I_HI:I_LO] = i_imm[11:0];
        w_err            = !imm_fits(i_imm, I_SB);
      end
      IMM_S: begin
        w_ins[S_UP_HI:S_UP_LO] = i_imm[11:5];
        w_ins[S_DN_HI:S_DN_LO] = i_imm[4:0];
        w_err                  = !imm_fits(i_imm, I_SB);
      end
      IMM_B: begin
        w_ins[B_SIGN]          = i_imm[12];
        w_ins[B_UP_HI:B_UP_LO] = i_imm[10:5];
        w_ins[B_DN_HI:B_DN_LO] = i_imm[4:1];
        w_ins[B_B11]           = i_imm[11];
        w_err                  = !imm_fits(i_imm, B_SB);
        w_mis                  = i_imm[0];
      end
      IMM_J: begin
        w_ins[J_SIGN]          = i_imm[20];
        w_ins[J_DN_HI:J_DN_LO] = i_imm[10:1];
        w_ins[J_B11]           = i_imm[11];
        w_ins[J_UP_HI:J_UP_LO] = i_imm[19:12];
        w_err                  = !imm_fits(i_imm, J_SB);
        w_mis                  = i_imm[0];
      end
      default: ;
    endcase
  end

  assign o_res = '{instr: w_ins[31:7], err: w_err, misalign: w_mis};

endmodule
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module    : imm_encoder                                                    |
// | Purpose   : Streaming valid/ready immediate encoder. Packs the immediate   |
// |             into instr[31:7] (via imm_pack), registers the result with a   |
// |             1-cycle latency, and buffers one extra item in a skid entry    |
// |             so o_ready can be a plain register.                            |
// | Ports     : i_clk, i_rst (sync, active-high)                               |
// |             i_valid/o_ready, i_immsrc, i_imm, i_base   input stream        |
// |             o_valid/i_ready, o_instr, o_err, o_misalign output stream      |
// |             o_err_cnt  saturating error count                              |
// | Options   : IMM_ERR_CNT_EN  enables the error counter; otherwise           |
// |             o_err_cnt is tied to zero.                                     |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module imm_encoder
  import imm_pkg::*;
#(
  parameter bit          DROP_ON_ERR = 1'b0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_immsrc,
  input  logic [31:0]      i_imm,
  input  logic [24:0]      i_base,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [24:0]      o_instr,
  output logic             o_err,
  output logic             o_misalign,
  output logic [CNT_W-1:0] o_err_cnt
);

  imm_res_t w_new;
  logic     w_accept;
  logic     w_bad;
  logic     w_fwd;
  logic     w_pop;

  imm_res_t out_q,    out_d;
  logic     out_v_q,  out_v_d;
  imm_res_t skid_q,   skid_d;
  logic     skid_v_q, skid_v_d;
  logic     ready_q,  ready_d;

  imm_pack u_pack (
    .i_immsrc (i_immsrc),
    .i_imm    (i_imm),
    .i_base   (i_base),
    .o_res    (w_new)
  );

  assign w_accept = i_valid && ready_q;
  assign w_bad    = w_new.err || w_new.misalign;
  // In drop mode a bad item is still consumed, it just never reaches the output
  assign w_fwd    = w_accept && !(DROP_ON_ERR && w_bad);
  assign w_pop    = out_v_q && i_ready;

  always_comb begin
    out_d    = out_q;
    out_v_d  = out_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (!out_v_q || w_pop) begin
      // Output slot frees up: the oldest item (skid first) moves in
      if (skid_v_q) begin
        out_d    = skid_q;
        out_v_d  = 1'b1;
        skid_v_d = 1'b0;
        if (w_fwd) begin
          skid_d   = w_new;
          skid_v_d = 1'b1;
        end
      end else begin
        out_v_d = w_fwd;
        if (w_fwd) begin
          out_d = w_new;
        end
      end
    end else if (w_fwd) begin
      // Output stalled: the item accepted this cycle parks in the skid entry
      skid_d   = w_new;
      skid_v_d = 1'b1;
    end
    ready_d = !skid_v_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_q    <= '0;
      out_v_q  <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      out_q    <= out_d;
      out_v_q  <= out_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      ready_q  <= ready_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = out_v_q;
  assign o_instr    = out_q.instr;
  assign o_err      = out_q.err;
  assign o_misalign = out_q.misalign;

`ifdef IMM_ERR_CNT_EN
  // Counts at the input handshake, so dropped items are included
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (w_accept && w_bad && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_err_cnt = cnt_q;
`else
  assign o_err_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module    : tb_imm_encoder                                                 |
// | Purpose   : Scoreboard bench for imm_encoder. DUT A forwards errors,       |
// |             DUT B drops them (CNT_W=2). Expected items are queued at the   |
// |             input handshake; monitors pop and compare on output handshakes.|
// |             Expected values come from arithmetic range rules and from      |
// |             decoding o_instr with the standard immediate extender.         |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_imm_encoder;
  import imm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rdy;
  bit   rdy_rand;

  logic        a_valid, a_ordy, a_ov, a_err, a_mis;
  logic [1:0]  a_src;
  logic [31:0] a_imm;
  logic [24:0] a_base, a_instr;
  logic [15:0] a_cnt;

  logic        b_valid, b_ordy, b_ov, b_err, b_mis;
  logic [1:0]  b_src;
  logic [31:0] b_imm;
  logic [24:0] b_base, b_instr;
  logic [1:0]  b_cnt;

  imm_encoder #(.DROP_ON_ERR(1'b0), .CNT_W(16)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .o_ready(a_ordy),
    .i_immsrc(a_src), .i_imm(a_imm), .i_base(a_base),
    .o_valid(a_ov), .i_ready(rdy), .o_instr(a_instr), .o_err(a_err),
    .o_misalign(a_mis), .o_err_cnt(a_cnt)
  );

  imm_encoder #(.DROP_ON_ERR(1'b1), .CNT_W(2)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_ready(b_ordy),
    .i_immsrc(b_src), .i_imm(b_imm), .i_base(b_base),
    .o_valid(b_ov), .i_ready(rdy), .o_instr(b_instr), .o_err(b_err),
    .o_misalign(b_mis), .o_err_cnt(b_cnt)
  );

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [24:0] base;
    logic        err;
    logic        mis;
    logic [31:0] dec;
    bit          exact;
    logic [24:0] instr;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cnt_a  = 0;
  int   cnt_b  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] sx(input logic [31:0] v, input int n);
    logic [31:0] t;
    t = v << (32 - n);
    return $signed(t) >>> (32 - n);
  endfunction

  function automatic int imm_w(input logic [1:0] s);
    return (s == IMM_J) ? 21 : (s == IMM_B) ? 13 : 12;
  endfunction

  function automatic logic m_err(input logic [1:0] s, input logic [31:0] imm);
    int signed v;
    int signed lim;
    v   = signed'(imm);
    lim = 1 <<< (imm_w(s) - 1);
    return (v < -lim) || (v >= lim);
  endfunction

  // Value the extender must give back: immediate truncated to the format width
  function automatic logic [31:0] m_dec(input logic [1:0] s, input logic [31:0] imm);
    logic [31:0] v;
    v = sx(imm, imm_w(s));
    if (s == IMM_B || s == IMM_J) v[0] = 1'b0;
    return v;
  endfunction

  // Standard immediate extender, applied to instr[31:7]
  function automatic logic [31:0] extend(input logic [1:0] s, input logic [24:0] o);
    logic [31:0] n;
    n = {o, 7'b0};
    case (s)
      IMM_I:   return {{20{n[31]}}, n[31:20]};
      IMM_S:   return {{20{n[31]}}, n[31:25], n[11:7]};
      IMM_B:   return {{19{n[31]}}, n[31], n[7], n[30:25], n[11:8], 1'b0};
      default: return {{11{n[31]}}, n[31], n[19:12], n[20], n[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] owned(input logic [1:0] s);
    case (s)
      IMM_I:   return 32'hFFF0_0000;
      IMM_J:   return 32'hFFFF_F000;
      default: return 32'hFE00_0F80;
    endcase
  endfunction

  function automatic logic [31:0] rand_imm(input logic [1:0] s);
    int k;
    logic [31:0] v;
    k = $urandom_range(0, 7);
    if (k == 0) return $urandom;
    v = sx($urandom, imm_w(s));
    if ((s == IMM_B || s == IMM_J) && k != 1) v[0] = 1'b0;
    return v;
  endfunction

  // ---------------- ready generator ----------------
  always @(posedge clk) begin
    #1;
    if (rdy_rand) rdy = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver ----------------
  task automatic send(input bit sel_b, input logic [1:0] s, input logic [31:0] imm,
                      input logic [24:0] base, input bit ex, input logic [24:0] ei);
    exp_t e;
    bit   acc;
    int   waited;
    acc = 0;
    waited = 0;
    if (!sel_b) begin a_valid = 1; a_src = s; a_imm = imm; a_base = base; end
    else        begin b_valid = 1; b_src = s; b_imm = imm; b_base = base; end
    while (!acc && waited <= 200) begin
      @(negedge clk);
      if (sel_b ? b_ordy : a_ordy) acc = 1;
      else waited++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    else begin
      e = '{src: s, imm: imm, base: base, err: m_err(s, imm),
            mis: (s == IMM_B || s == IMM_J) && imm[0],
            dec: m_dec(s, imm), exact: ex, instr: ei};
      if (!sel_b) begin
        qa.push_back(e);
        if ((e.err || e.mis) && cnt_a < 65535) cnt_a++;
      end else begin
        if (!(e.err || e.mis)) qb.push_back(e);
        if ((e.err || e.mis) && cnt_b < 3) cnt_b++;
      end
    end
    @(posedge clk);
    #1;
    a_valid = 0;
    b_valid = 0;
  endtask

  task automatic drain(input bit sel_b);
    int waited;
    waited = 0;
    rdy_rand = 0;
    rdy = 1;
    while ((sel_b ? qb.size() : qa.size()) != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk(sel_b ? "b_drain_left" : "a_drain_left", sel_b ? qb.size() : qa.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitors ----------------
  task automatic compare(input string p, input exp_t e, input logic [24:0] ins,
                         input logic er, input logic mi);
    chk({p, "_err"}, er, e.err);
    chk({p, "_misalign"}, mi, e.mis);
    chk({p, "_roundtrip"}, extend(e.src, ins), e.dec);
    chk({p, "_base_bits"}, {ins, 7'b0} & ~owned(e.src), {e.base, 7'b0} & ~owned(e.src));
    if (e.exact) chk({p, "_instr"}, ins, e.instr);
  endtask

  bit          a_hold = 0, b_hold = 0;
  logic [26:0] a_prev, b_prev;

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst) a_hold = 0;
    else begin
      if (a_hold) begin
        chk("a_hold_valid", a_ov, 1);
        chk("a_hold_data", {a_instr, a_err, a_mis}, a_prev);
      end
      if (a_ov && rdy) begin
        if (qa.size() == 0) chk("a_unexpected_item", 1, 0);
        else begin e = qa.pop_front(); compare("a", e, a_instr, a_err, a_mis); end
      end
      a_hold = a_ov && !rdy;
      a_prev = {a_instr, a_err, a_mis};
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst) b_hold = 0;
    else begin
      if (b_hold) begin
        chk("b_hold_valid", b_ov, 1);
        chk("b_hold_data", {b_instr, b_err, b_mis}, b_prev);
      end
      if (b_ov && rdy) begin
        if (qb.size() == 0) chk("b_unexpected_item", 1, 0);
        else begin e = qb.pop_front(); compare("b", e, b_instr, b_err, b_mis); end
      end
      b_hold = b_ov && !rdy;
      b_prev = {b_instr, b_err, b_mis};
    end
  end

  function automatic int cnt_exp(input int c);
`ifdef IMM_ERR_CNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  logic [31:0] bnd [18] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'd2047, 32'd2048,
                            -32'sd2048, -32'sd2049, 32'd4094, 32'd4095, 32'd4096,
                            -32'sd4096, -32'sd4097, 32'h000F_FFFE, 32'h0010_0000,
                            32'hFFF0_0000, 32'hFFEF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000};

  // ---------------- main sequence ----------------
  initial begin
    rst = 1; rdy = 0; rdy_rand = 0;
    a_valid = 0; a_src = 0; a_imm = 0; a_base = 0;
    b_valid = 0; b_src = 0; b_imm = 0; b_base = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_o_valid", a_ov, 0);
    chk("rst_o_instr", a_instr, 0);
    chk("rst_o_err", {a_err, a_mis}, 0);
    chk("rst_o_err_cnt", a_cnt, 0);
    chk("rst_o_ready_low", a_ordy, 0);
    chk("rst_b_o_valid", b_ov, 0);
    @(posedge clk); #1;
    rst = 0; rdy = 1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_release", a_ordy, 1);
    @(posedge clk); #1;

    // Directed vectors
    send(0, IMM_I, 32'hFFFF_FFFF, 25'd0, 1, 25'h1FF_E000);
    @(negedge clk);
    chk("latency_1_cycle", a_ov, 1);
    @(posedge clk); #1;
    send(0, IMM_I, 32'h0000_0800, 25'd0, 0, 25'd0);
    send(0, IMM_B, 32'hFFFF_F000, 25'd0, 1, 25'h100_0000);
    send(0, IMM_B, 32'd3, $urandom, 0, 25'd0);
    send(0, IMM_S, -32'sd2048, $urandom, 0, 25'd0);
    send(0, IMM_J, 32'h000F_FFFE, 25'd0, 1, 25'h0FF_FFE0);
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 18; i++)
        send(0, 2'(s), bnd[i], $urandom, 0, 25'd0);
    drain(0);
    chk("cnt_after_directed", a_cnt, cnt_exp(cnt_a));

    // Random traffic with random backpressure
    rdy_rand = 1;
    for (int i = 0; i < 10000; i++) begin
      logic [1:0] s;
      s = 2'($urandom_range(0, 3));
      send(0, s, rand_imm(s), $urandom, 0, 25'd0);
    end
    drain(0);
    chk("cnt_after_random", a_cnt, cnt_exp(cnt_a));

    // Backpressure: three back-to-back items, downstream stalled for 3 edges
    rdy = 0;
    fork
      begin
        send(0, IMM_I, 32'd100, 25'h0AA_AAAA, 0, 25'd0);
        send(0, IMM_S, 32'd200, 25'h155_5555, 0, 25'd0);
        send(0, IMM_J, 32'd300, 25'h0F0_F0F0, 0, 25'd0);
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_ready_drops", a_ordy, 0);
        chk("bp_out_valid", a_ov, 1);
        @(posedge clk); #1;
        rdy = 1;
        @(negedge clk);
        chk("bp_ready_still_low", a_ordy, 0);
        @(negedge clk);
        chk("bp_ready_back", a_ordy, 1);
      end
    join
    drain(0);

    // Reset with two errored items buffered
    rdy = 0;
    send(0, IMM_I, 32'h0000_0800, 25'd0, 0, 25'd0);
    send(0, IMM_S, 32'h0001_0000, 25'd0, 0, 25'd0);
    chk("pre_reset_cnt", a_cnt, cnt_exp(cnt_a));
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_o_valid", a_ov, 0);
    chk("midrst_o_err_cnt", a_cnt, 0);
    chk("midrst_o_ready", a_ordy, 0);
    qa.delete();
    cnt_a = 0;
    cnt_b = 0;
    @(posedge clk); #1;
    rst = 0; rdy = 1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready_after_release", a_ordy, 1);
    chk("midrst_no_output", a_ov, 0);
    @(posedge clk); #1;

    // Drop mode and counter saturation (CNT_W=2)
    send(1, IMM_I, 32'h0000_0800, 25'd0, 0, 25'd0);
    repeat (3) begin
      @(negedge clk);
      chk("drop_no_valid", b_ov, 0);
    end
    chk("drop_cnt_1", b_cnt, cnt_exp(cnt_b));
    @(posedge clk); #1;
    send(1, IMM_I, 32'h0000_0800, 25'd0, 0, 25'd0);
    send(1, IMM_B, 32'd3, 25'd0, 0, 25'd0);
    send(1, IMM_J, 32'h0010_0000, 25'd0, 0, 25'd0);
    send(1, IMM_S, -32'sd2049, 25'd0, 0, 25'd0);
    @(negedge clk);
    chk("drop_cnt_saturated", b_cnt, cnt_exp(cnt_b));
    chk("drop_still_no_valid", b_ov, 0);
    @(posedge clk); #1;
    rdy_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] s;
      s = 2'($urandom_range(0, 3));
      send(1, s, rand_imm(s), $urandom, 0, 25'd0);
    end
    drain(1);
    chk("drop_cnt_final", b_cnt, cnt_exp(cnt_b));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
